// File: rtl/cpu_gen2_pkg.sv
// cpu_gen2_pkg
// Shared definitions for the second-generation accumulator CPU:
//   - state_e      : control state machine encoding
//   - OP_*         : 3-bit opcode values of the instruction format
//   - field helpers: bit positions of the I bit and opcode field as a
//                    function of the data width
//   - state decode : which states drive the read / write / halted strobes
package cpu_gen2_pkg;

  typedef enum logic [2:0] {
    FETCH_A  = 3'd0,
    FETCH_M  = 3'd1,
    DECODE   = 3'd2,
    INDIR    = 3'd3,
    EXEC_RD  = 3'd4,
    EXEC_ALU = 3'd5,
    STORE    = 3'd6,
    HALT     = 3'd7
  } state_e;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_LDA = 3'd4;
  localparam logic [2:0] OP_STA = 3'd5;
  localparam logic [2:0] OP_JMP = 3'd6;
  // Opcode 7 is JZ when direct and HLT when the I bit is set.
  localparam logic [2:0] OP_JZ  = 3'd7;

  // The indirect bit is always the instruction MSB.
  function automatic int iBitPos(input int dataW);
    return dataW - 1;
  endfunction

  // The opcode occupies the three bits directly below the indirect bit.
  function automatic int opMsbPos(input int dataW);
    return dataW - 2;
  endfunction

  function automatic int opLsbPos(input int dataW);
    return dataW - 4;
  endfunction

  // States that hold a memory read open until mem_ready.
  function automatic logic isReadState(input state_e s);
    return (s == FETCH_M) || (s == INDIR) || (s == EXEC_RD);
  endfunction

endpackage

// File: rtl/cpu_gen2_alu.sv
// cpu_gen2_alu
// Combinational arithmetic/logic unit of the accumulator CPU.
// Ports:
//   op_i     : opcode of the executing instruction
//   ac_i     : current accumulator
//   dr_i     : operand fetched from memory
//   e_i      : current E (carry) flag
//   result_o : new accumulator value
//   eNext_o  : new E flag (ADD carry-out, SUB not-borrow, else unchanged)
module cpu_gen2_alu
  import cpu_gen2_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] ac_i,
  input  logic [DATA_W-1:0] dr_i,
  input  logic              e_i,
  output logic [DATA_W-1:0] result_o,
  output logic              eNext_o
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // One extra bit on both sums exposes the carry and the borrow; SUB sets
  // E when no borrow occurred, i.e. AC >= DR.
  always_comb begin
    sum      = {1'b0, ac_i} + {1'b0, dr_i};
    diff     = {1'b0, ac_i} - {1'b0, dr_i};
    result_o = ac_i;
    eNext_o  = e_i;
    case (op_i)
      OP_AND: result_o = ac_i & dr_i;
      OP_ADD: begin
        result_o = sum[DATA_W-1:0];
        eNext_o  = sum[DATA_W];
      end
      OP_SUB: begin
        result_o = diff[DATA_W-1:0];
        eNext_o  = ~diff[DATA_W];
      end
      OP_OR:  result_o = ac_i | dr_i;
      OP_LDA: result_o = dr_i;
      default: begin
        result_o = ac_i;
        eNext_o  = e_i;
      end
    endcase
  end

endmodule

// File: rtl/cpu_gen2.sv
// cpu_gen2
// Parametrised accumulator CPU that drives a shared single-port memory
// directly, with a ready handshake so the memory may insert wait states.
// DATA_W must be at least ADDR_W+4 so the I bit, opcode and address fit.
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous active-low reset
//   mem_ready : memory completes the current read/write this cycle
//   mem_rdata : read data, valid when read && mem_ready
//   address   : memory address (the AR register)
//   mem_wdata : write data (AC while write, else 0)
//   read      : memory read strobe
//   write     : memory write strobe
//   halted    : CPU is in HALT
//   acc       : accumulator value
//   carry     : E flag
module cpu_gen2
  import cpu_gen2_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              read,
  output logic              write,
  output logic              halted,
  output logic [DATA_W-1:0] acc,
  output logic              carry
);

  localparam int IBIT   = iBitPos(DATA_W);
  localparam int OP_MSB = opMsbPos(DATA_W);
  localparam int OP_LSB = opLsbPos(DATA_W);

  state_e            stateQ, stateD;
  logic [ADDR_W-1:0] pcQ, pcD;
  logic [ADDR_W-1:0] arQ, arD;
  logic [DATA_W-1:0] irQ, irD;
  logic [DATA_W-1:0] drQ, drD;
  logic [DATA_W-1:0] acQ, acD;
  logic              eQ, eD;
  logic              readQ, writeQ, haltedQ;

  logic              iBit;
  logic [2:0]        opField;
  logic [ADDR_W-1:0] addrField;
  logic [ADDR_W-1:0] ptr;
  state_e            dispState;
  logic              takeJump;
  logic [DATA_W-1:0] aluResult;
  logic              aluE;

  assign iBit      = irQ[IBIT];
  assign opField   = irQ[OP_MSB:OP_LSB];
  assign addrField = irQ[ADDR_W-1:0];

  cpu_gen2_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op_i    (opField),
    .ac_i    (acQ),
    .dr_i    (drQ),
    .e_i     (eQ),
    .result_o(aluResult),
    .eNext_o (aluE)
  );

  // Operand dispatch shared by DECODE and INDIR. In INDIR the effective
  // address is the pointer arriving on the bus, so jumps and stores use it
  // in the same cycle it is latched into AR.
  always_comb begin
    ptr       = (stateQ == INDIR) ? mem_rdata[ADDR_W-1:0] : addrField;
    dispState = EXEC_RD;
    takeJump  = 1'b0;
    case (opField)
      OP_JMP: begin
        dispState = FETCH_A;
        takeJump  = 1'b1;
      end
      OP_JZ: begin
        dispState = FETCH_A;
        takeJump  = (acQ == '0);
      end
      OP_STA:  dispState = STORE;
      default: dispState = EXEC_RD;
    endcase
  end

  // Next-state logic. Memory states hold all registers (and hence the bus)
  // until mem_ready; mem_ready in any other state has no effect.
  always_comb begin
    stateD = stateQ;
    pcD    = pcQ;
    arD    = arQ;
    irD    = irQ;
    drD    = drQ;
    acD    = acQ;
    eD     = eQ;
    unique case (stateQ)
      FETCH_A: begin
        arD    = pcQ;
        stateD = FETCH_M;
      end
      FETCH_M: begin
        if (mem_ready) begin
          irD    = mem_rdata;
          pcD    = pcQ + ADDR_W'(1);
          stateD = DECODE;
        end
      end
      DECODE: begin
        arD = addrField;
        if (opField == OP_JZ && iBit) begin
          stateD = HALT;
        end else if (iBit) begin
          stateD = INDIR;
        end else begin
          stateD = dispState;
          if (takeJump) pcD = ptr;
        end
      end
      INDIR: begin
        if (mem_ready) begin
          arD    = ptr;
          stateD = dispState;
          if (takeJump) pcD = ptr;
        end
      end
      EXEC_RD: begin
        if (mem_ready) begin
          drD    = mem_rdata;
          stateD = EXEC_ALU;
        end
      end
      EXEC_ALU: begin
        acD    = aluResult;
        eD     = aluE;
        stateD = FETCH_A;
      end
      STORE: begin
        if (mem_ready) stateD = FETCH_A;
      end
      HALT: stateD = HALT;
      default: stateD = FETCH_A;
    endcase
  end

  // State register. The strobes are decoded from the next state so they
  // are registered yet still exactly track the current state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stateQ  <= FETCH_A;
      pcQ     <= '0;
      arQ     <= '0;
      irQ     <= '0;
      drQ     <= '0;
      acQ     <= '0;
      eQ      <= 1'b0;
      readQ   <= 1'b0;
      writeQ  <= 1'b0;
      haltedQ <= 1'b0;
    end else begin
      stateQ  <= stateD;
      pcQ     <= pcD;
      arQ     <= arD;
      irQ     <= irD;
      drQ     <= drD;
      acQ     <= acD;
      eQ      <= eD;
      readQ   <= isReadState(stateD);
      writeQ  <= (stateD == STORE);
      haltedQ <= (stateD == HALT);
    end
  end

  assign address   = arQ;
  assign mem_wdata = writeQ ? acQ : '0;
  assign read      = readQ;
  assign write     = writeQ;
  assign halted    = haltedQ;
  assign acc       = acQ;
  assign carry     = eQ;

endmodule

// File: tb/tb_cpu_gen2.sv
// tb_cpu_gen2
// Self-checking bench for cpu_gen2 (DATA_W=8, ADDR_W=4). A behavioural
// memory answers the bus with a programmable number of wait states; every
// expected bus access (kind, address, write data, completion cycle) is
// queued before a program starts and compared as the access completes.
module tb_cpu_gen2;
  import cpu_gen2_pkg::*;

  logic       clk;
  logic       reset;
  logic       memReady;
  logic [7:0] memRdata;
  logic [3:0] address;
  logic [7:0] memWdata;
  logic       read;
  logic       write;
  logic       halted;
  logic [7:0] acc;
  logic       carry;

  logic [7:0] mem [16];

  typedef struct {
    bit         isWrite;
    logic [3:0] addr;
    logic [7:0] data;
    int         cyc;
  } access_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] expAcc;
    logic       expCarry;
  } vec_t;

  access_t    expQ[$];
  vec_t       vecs[9];
  int         checks;
  int         errors;
  int         cyc;
  int         readWaits;
  int         writeWaits;
  int         waitCnt;
  int         lim;
  logic [3:0] latAddr;
  logic       latRead;
  logic       latWrite;
  logic [7:0] latWdata;
  access_t    got;

  cpu_gen2 #(
    .DATA_W(8),
    .ADDR_W(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_ready(memReady),
    .mem_rdata(memRdata),
    .address  (address),
    .mem_wdata(memWdata),
    .read     (read),
    .write    (write),
    .halted   (halted),
    .acc      (acc),
    .carry    (carry)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign memRdata = mem[address];

  // Cycle 0 is the first cycle after the last reset edge
  always @(posedge clk) begin
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: stretch each access by the configured wait count, check the
  // bus holds steady while stalled, and retire the access against the queue
  always @(negedge clk) begin
    if (read || write) begin
      lim = write ? writeWaits : readWaits;
      if (waitCnt == 0) begin
        latAddr  = address;
        latRead  = read;
        latWrite = write;
        latWdata = memWdata;
      end else begin
        checkOutput("holdAddr", 32'(address), 32'(latAddr));
        checkOutput("holdRead", 32'(read), 32'(latRead));
        checkOutput("holdWrite", 32'(write), 32'(latWrite));
        checkOutput("holdWdata", 32'(memWdata), 32'(latWdata));
      end
      if (waitCnt >= lim) begin
        memReady = 1'b1;
        waitCnt  = 0;
        if (write) mem[address] = memWdata;
        if (expQ.size() > 0) begin
          got = expQ.pop_front();
          checkOutput("accessKind", 32'(write), 32'(got.isWrite));
          checkOutput("accessAddr", 32'(address), 32'(got.addr));
          if (got.isWrite) checkOutput("writeData", 32'(memWdata), 32'(got.data));
          checkOutput("accessCycle", 32'(cyc), 32'(got.cyc));
        end else begin
          checks++;
          errors++;
          $display("[TB] FAIL strayAccess: got write=%0b addr=0x%0h, required no access (cycle %0d)",
                   write, address, cyc);
        end
      end else begin
        memReady = 1'b0;
        waitCnt++;
      end
    end else begin
      memReady = 1'b1;
      waitCnt  = 0;
    end
  end

  task automatic expectAccess(input bit w, input int a, input int d, input int c);
    access_t e;
    e.isWrite = w;
    e.addr    = 4'(a);
    e.data    = 8'(d);
    e.cyc     = c;
    expQ.push_back(e);
  endtask

  task automatic clearMem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  // Assert reset at a falling edge; after the first reset edge the bus is
  // idle, so memory and expectations may be reloaded safely
  task automatic beginReset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    expQ.delete();
  endtask

  // Second reset edge, check the reset outputs, then release
  task automatic endReset();
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstRead", 32'(read), 32'd0);
    checkOutput("rstWrite", 32'(write), 32'd0);
    checkOutput("rstAddr", 32'(address), 32'd0);
    checkOutput("rstAcc", 32'(acc), 32'd0);
    checkOutput("rstCarry", 32'(carry), 32'd0);
    checkOutput("rstHalted", 32'(halted), 32'd0);
    reset = 1'b1;
  endtask

  task automatic waitCycle(input int target);
    int n = 0;
    while (cyc != target && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reachCycle", 32'(cyc), 32'(target));
  endtask

  task automatic waitHalted(input int expCyc);
    int n = 0;
    while (!halted && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("haltCycle", 32'(cyc), 32'(expCyc));
  endtask

  task automatic loadMain();
    clearMem();
    mem[0]  = 8'h4A;
    mem[1]  = 8'h1B;
    mem[2]  = 8'h5C;
    mem[3]  = 8'hF0;
    mem[10] = 8'hF0;
    mem[11] = 8'h25;
  endtask

  // Main program accesses; each wait state delays this and all later ones
  task automatic pushMain(input int w, input int count);
    int baseC[7] = '{1, 3, 6, 8, 11, 13, 15};
    int addrs[7] = '{0, 10, 1, 11, 2, 12, 3};
    for (int k = 0; k < count; k++)
      expectAccess(k == 5, addrs[k], 8'h15, baseC[k] + w * (k + 1));
  endtask

  // Run LDA 8 / <op> 9 / HLT with operands a and b
  task automatic applyStimulus(input vec_t v);
    beginReset();
    clearMem();
    mem[0] = 8'h48;
    mem[1] = {1'b0, v.op, 4'h9};
    mem[2] = 8'hF0;
    mem[8] = v.a;
    mem[9] = v.b;
    expectAccess(0, 0, 0, 1);
    expectAccess(0, 8, 0, 3);
    expectAccess(0, 1, 0, 6);
    expectAccess(0, 9, 0, 8);
    expectAccess(0, 2, 0, 11);
    endReset();
    waitHalted(13);
    checkOutput("vecAcc", 32'(acc), 32'(v.expAcc));
    checkOutput("vecCarry", 32'(carry), 32'(v.expCarry));
    checkOutput("vecDrained", 32'(expQ.size()), 32'd0);
  endtask

  // Whole-run watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence
  initial begin
    int n;
    checks     = 0;
    errors     = 0;
    readWaits  = 0;
    writeWaits = 0;
    waitCnt    = 0;
    reset      = 1'b0;
    memReady   = 1'b1;
    clearMem();

    vecs[0] = '{OP_ADD, 8'hF0, 8'h25, 8'h15, 1'b1};
    vecs[1] = '{OP_ADD, 8'h12, 8'h34, 8'h46, 1'b0};
    vecs[2] = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[3] = '{OP_SUB, 8'h50, 8'h20, 8'h30, 1'b1};
    vecs[4] = '{OP_SUB, 8'h20, 8'h50, 8'hD0, 1'b0};
    vecs[5] = '{OP_SUB, 8'h33, 8'h33, 8'h00, 1'b1};
    vecs[6] = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vecs[7] = '{OP_OR,  8'hF0, 8'h0C, 8'hFC, 1'b0};
    vecs[8] = '{OP_LDA, 8'h48, 8'h5A, 8'h5A, 1'b0};

    // Main program interrupted by a reset part-way through
    beginReset();
    loadMain();
    pushMain(0, 4);
    endReset();
    waitCycle(8);
    checkOutput("midAcc", 32'(acc), 32'hF0);

    // Full main program from a clean reset
    beginReset();
    loadMain();
    pushMain(0, 7);
    endReset();
    waitHalted(17);
    checkOutput("mainAcc", 32'(acc), 32'h15);
    checkOutput("mainCarry", 32'(carry), 32'd1);
    checkOutput("mainMem12", 32'(mem[12]), 32'h15);
    repeat (10) @(negedge clk);
    checkOutput("haltHold", 32'(halted), 32'd1);
    checkOutput("mainDrained", 32'(expQ.size()), 32'd0);

    // Same program with three wait states on every access
    readWaits  = 3;
    writeWaits = 3;
    beginReset();
    loadMain();
    pushMain(3, 7);
    endReset();
    waitHalted(38);
    checkOutput("waitMem12", 32'(mem[12]), 32'h15);
    checkOutput("waitAcc", 32'(acc), 32'h15);
    checkOutput("waitDrained", 32'(expQ.size()), 32'd0);
    readWaits  = 0;
    writeWaits = 0;

    // Indirect LDA through pointer at 9
    beginReset();
    clearMem();
    mem[0]  = 8'hC9;
    mem[1]  = 8'hF0;
    mem[9]  = 8'h0E;
    mem[14] = 8'h77;
    expectAccess(0, 0, 0, 1);
    expectAccess(0, 9, 0, 3);
    expectAccess(0, 14, 0, 4);
    expectAccess(0, 1, 0, 7);
    endReset();
    waitCycle(6);
    checkOutput("indirAcc", 32'(acc), 32'h77);
    waitHalted(9);

    // Table-driven ALU vectors
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // JZ taken with AC = 0
    beginReset();
    clearMem();
    mem[0] = 8'h78;
    mem[8] = 8'hF0;
    expectAccess(0, 0, 0, 1);
    expectAccess(0, 8, 0, 4);
    endReset();
    waitHalted(6);

    // JZ not taken with AC = 1
    beginReset();
    clearMem();
    mem[0]  = 8'h4D;
    mem[1]  = 8'h78;
    mem[2]  = 8'hF0;
    mem[8]  = 8'hF0;
    mem[13] = 8'h01;
    expectAccess(0, 0, 0, 1);
    expectAccess(0, 13, 0, 3);
    expectAccess(0, 1, 0, 6);
    expectAccess(0, 2, 0, 9);
    endReset();
    waitHalted(11);

    // JMP 15 then PC wraps to 0 after fetching the instruction at 15
    beginReset();
    clearMem();
    mem[0]  = 8'h6F;
    mem[15] = 8'h4E;
    mem[14] = 8'h00;
    expectAccess(0, 0, 0, 1);
    expectAccess(0, 15, 0, 4);
    expectAccess(0, 14, 0, 6);
    expectAccess(0, 0, 0, 9);
    endReset();
    waitCycle(10);
    checkOutput("wrapDrained", 32'(expQ.size()), 32'd0);

    // Reset while a store is stalled by the memory
    writeWaits = 1000;
    beginReset();
    loadMain();
    mem[12] = 8'hAA;
    pushMain(0, 5);
    endReset();
    n = 0;
    while (!write && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("storeCycle", 32'(cyc), 32'd13);
    beginReset();
    checkOutput("storeAbortWrite", 32'(write), 32'd0);
    checkOutput("storeAbortMem", 32'(mem[12]), 32'hAA);
    writeWaits = 0;
    pushMain(0, 7);
    endReset();
    waitHalted(17);
    checkOutput("restartMem12", 32'(mem[12]), 32'h15);
    checkOutput("restartDrained", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_gen2.md
Name: cpu_gen2

Overview:
- Parametrised second-generation accumulator CPU for the single-bus RISC family.
- Keeps the established instruction format: indirect bit, 3-bit opcode, address field.
- Generalises data and address widths.
- Adds a memory ready handshake (wait states), conditional branch, jump and halt.
- Drives the shared external memory directly: address, read/write strobes, write data.

Parameters:
- DATA_W, 8, data/instruction width; legal only if DATA_W >= ADDR_W+4.
- ADDR_W, 4, address width; PC, AR and memory depth 2^ADDR_W.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- mem_ready  in  1  memory completes the current read/write this cycle.
- mem_rdata  in  DATA_W  read data; valid when read && mem_ready.
- address  out  ADDR_W  memory address (= AR).
- mem_wdata  out  DATA_W  write data (= AC while write, else 0).
- read  out  1  memory read strobe.
- write  out  1  memory write strobe.
- halted  out  1  CPU in HALT state.
- acc  out  DATA_W  accumulator value.
- carry  out  1  E flag.

Behaviour:
- Instruction fields: IR[DATA_W-1]=I; IR[DATA_W-2:DATA_W-4]=op; IR[ADDR_W-1:0]=addr; other bits ignored.
- Opcodes: 0 AND; 1 ADD; 2 SUB; 3 OR; 4 LDA; 5 STA; 6 JMP; 7 JZ when I=0, HLT when I=1 (HLT never indirect).
- Reset (reset==0 at clk edge): state=FETCH_A; PC, AR, IR, DR, AC=0; E=0.
- Reset gives read=write=0, halted=0, address=0, acc=0, carry=0, effective the cycle after the edge.
- Reset overrides everything, including mid-access and HALT.
- Outputs are Moore-decoded from state.
- read=1 in FETCH_M, INDIR, EXEC_RD.
- write=1 in STORE.
- halted=1 in HALT.
- State machine:
  - FETCH_A: AR<=PC; ->FETCH_M.
  - FETCH_M: hold until mem_ready; then IR<=mem_rdata, PC<=PC+1 mod 2^ADDR_W; ->DECODE.
  - DECODE: AR<=addr.
    - HLT ->HALT.
    - I=1 ->INDIR.
    - Else JMP: PC<=addr, ->FETCH_A.
    - Else JZ: PC<=addr if AC==0, ->FETCH_A.
    - Else STA ->STORE.
    - Else ->EXEC_RD.
  - INDIR: hold until mem_ready; then AR<=mem_rdata[ADDR_W-1:0] and the jump/branch/store/read dispatch as in DECODE, using the new pointer.
  - EXEC_RD: hold until mem_ready; then DR<=mem_rdata; ->EXEC_ALU.
  - EXEC_ALU: AC<=f(op,AC,DR); ->FETCH_A.
  - STORE: hold until mem_ready; write completes on the ready cycle; ->FETCH_A.
  - HALT: absorbing until reset.
- Handshake: while waiting, address, read/write and mem_wdata stay stable. mem_ready outside an access is ignored.
- Latency with mem_ready tied 1:
  - ALU/LDA: 5 cycles.
  - STA: 4 cycles.
  - JMP/JZ: 3 cycles.
  - Indirect: +1 cycle.
  - HLT: reaches HALT 3 cycles after its fetch starts.
  - Each wait cycle adds 1.
- Arithmetic: all modulo 2^DATA_W.
  - ADD: E=carry-out.
  - SUB: AC-DR, E=1 when no borrow (AC>=DR).
  - AND/OR/LDA: E unchanged.
- JZ tests AC at DECODE/INDIR.
- PC wraps from 2^ADDR_W-1 to 0.

Decomposition:
- Package cpu_gen2_pkg: state enum (FETCH_A, FETCH_M, DECODE, INDIR, EXEC_RD, EXEC_ALU, STORE, HALT), opcode constants, field-position functions of DATA_W/ADDR_W.
- One sub-module cpu_gen2_alu: combinational, parametrised DATA_W; inputs op, AC, DR, E; outputs result and E_next.

Test Plan:
- Reset: hold reset=0 two cycles mid-program -> read=write=0, address=0, acc=0, carry=0, halted=0. First read of address 0 in cycle 1 after release.
- Program (mem_ready=1): mem[0]=0x4A, [1]=0x1B, [2]=0x5C, [3]=0xF0, [10]=0xF0, [11]=0x25.
  - Required: mem[12]=0x15 written in cycle 13; carry=1; halted=1 from cycle 17 onward; no further reads/writes.
- Indirect: mem[0]=0xC9, [9]=0x0E, [14]=0x77 -> read addresses 0, 9, 14 in order; acc=0x77 after 6 cycles.
- Wait states: mem_ready low 3 cycles per access on the ADD program -> strobes/address/wdata stable while low; total time +3 per access; identical final memory.
- Branch/wrap, AC=0: JZ 8 (0x78) -> next fetch address 8.
- Branch/wrap, AC=0x01: same JZ -> fetch PC+1.
- Branch/wrap: JMP 15 (0x6F), instruction at 15 -> following fetch address 0.
- Reset mid-STORE with mem_ready=0 -> write=0 the cycle after the reset edge; target location unchanged; fetch restarts at 0.
